event_packer: RTL and testbench

//  Downstream of the block coordinator. Captures each completed event (timing tag + per-channel energies),

---
 rtl/event_packer.sv | 200 ++++++++++++++++++++
 tb/tb_event_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/event_packer.sv
// Event packer: buffers completed events and serializes them, plus period time-tag frames,
// as 16-bit words on a valid/ready link.
module event_packer #(
  parameter int NCH   = 4,
  parameter int EW    = 16,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done,
  input  logic              stall,
  input  logic [19:0]       start_time,
  input  logic [47:0]       start_period,
  input  logic [NCH*EW-1:0] energy,
  input  logic              period_done,
  input  logic [47:0]       period,
  output logic [15:0]       dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [7:0]        dropped,
  output logic              busy
);

  localparam int ENT_W = 28 + NCH * EW;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(NCH + 2);
  localparam logic [IW-1:0] EVT_LAST = IW'(NCH + 1);
  localparam logic [IW-1:0] TAG_LAST = IW'(3);

  typedef enum logic [1:0] {S_IDLE, S_EVT, S_TAG} state_t;

  // Entry layout: {start_time[19:0], start_period[7:0], energy}
  function automatic logic [15:0] evt_word(input logic [ENT_W-1:0] ent, input logic [IW-1:0] idx);
    logic [15:0] w;
    w = '0;
    if (idx == '0) begin
      w = {4'b1010, ent[ENT_W-1 -: 12]};
    end else if (idx == IW'(1)) begin
      w = {ent[ENT_W-13 -: 8], ent[NCH*EW +: 8]};
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (idx == IW'(c + 2)) w[EW-1:0] = ent[c*EW +: EW];
      end
    end
    return w;
  endfunction

  function automatic logic [15:0] tag_word(input logic [47:0] p, input logic [IW-1:0] idx);
    logic [15:0] w;
    if (idx == '0)          w = {4'b1100, p[47:36]};
    else if (idx == IW'(1)) w = p[35:20];
    else if (idx == IW'(2)) w = p[19:4];
    else                    w = {p[3:0], 12'h000};
    return w;
  endfunction

  state_t             state_q, state_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]   fifo_q [DEPTH];
  logic [ENT_W-1:0]   frame_q, frame_d;
  logic [47:0]        frame_tag_q, frame_tag_d;
  logic [47:0]        tag_reg_q, tag_reg_d;
  logic               tag_pending_q, tag_pending_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [15:0]        dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic [7:0]         dropped_q, dropped_d;

  logic               empty, full, push, accept, last_word, tag_go, frame_end;
  logic [ENT_W-1:0]   wdata, head;
  logic               unused_period_hi;

  assign unused_period_hi = ^start_period[47:8];

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push      = done && !full;
  assign wdata     = {start_time, start_period[7:0], energy};
  assign head      = fifo_q[rd_ptr_q[AW-1:0]];
  assign accept    = dout_valid_q && dout_ready;
  assign last_word = ((state_q == S_EVT) && (idx_q == EVT_LAST)) ||
                     ((state_q == S_TAG) && (idx_q == TAG_LAST));
  assign frame_end = accept && last_word;
  assign tag_go    = tag_pending_q && !stall;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (tag_go)      state_d = S_TAG;
        else if (!empty) state_d = S_EVT;
      end
      S_EVT, S_TAG: begin
        if (frame_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    frame_d      = frame_q;
    frame_tag_d  = frame_tag_q;
    idx_d        = idx_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    case (state_q)
      S_IDLE: begin
        if (tag_go) begin
          frame_tag_d  = tag_reg_q;
          idx_d        = '0;
          dout_d       = tag_word(tag_reg_q, '0);
          dout_valid_d = 1'b1;
        end else if (!empty) begin
          frame_d      = head;
          idx_d        = '0;
          dout_d       = evt_word(head, '0);
          dout_valid_d = 1'b1;
        end
      end
      S_EVT: begin
        if (accept) begin
          if (last_word) begin
            dout_valid_d = 1'b0;
          end else begin
            idx_d  = idx_q + IW'(1);
            dout_d = evt_word(frame_q, idx_q + IW'(1));
          end
        end
      end
      S_TAG: begin
        if (accept) begin
          if (last_word) begin
            dout_valid_d = 1'b0;
          end else begin
            idx_d  = idx_q + IW'(1);
            dout_d = tag_word(frame_tag_q, idx_q + IW'(1));
          end
        end
      end
      default: dout_valid_d = 1'b0;
    endcase
  end

  // FIFO slot is released only when its frame completes, so the entry being sent still occupies space.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? (AW+1)'(1) : '0);
    rd_ptr_d = rd_ptr_q + ((frame_end && (state_q == S_EVT)) ? (AW+1)'(1) : '0);
  end

  always_comb begin
    tag_reg_d     = period_done ? period : tag_reg_q;
    tag_pending_d = period_done || (tag_pending_q && !(frame_end && (state_q == S_TAG)));
    dropped_d     = dropped_q;
    if (done && full && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_q       <= '0;
      frame_tag_q   <= '0;
      tag_reg_q     <= '0;
      tag_pending_q <= 1'b0;
      idx_q         <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      dropped_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_q       <= frame_d;
      frame_tag_q   <= frame_tag_d;
      tag_reg_q     <= tag_reg_d;
      tag_pending_q <= tag_pending_d;
      idx_q         <= idx_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      dropped_q     <= dropped_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dropped    = dropped_q;
  assign busy       = (state_q != S_IDLE) || !empty || tag_pending_q;

endmodule

// File: tb/tb_event_packer.sv
// Directed testbench for event_packer: latency, back-pressure, overflow, tag/stall, tag overwrite, reset.
module tb_event_packer;

  localparam int NCH = 4;
  localparam int EW  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              done = 1'b0;
  logic              stall = 1'b0;
  logic [19:0]       start_time = '0;
  logic [47:0]       start_period = '0;
  logic [NCH*EW-1:0] energy = '0;
  logic              period_done = 1'b0;
  logic [47:0]       period = '0;
  logic [15:0]       dout;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic [7:0]        dropped;
  logic              busy;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_w [0:31];
  logic [15:0] bp_pat = 16'b0110_1001_1100_0101;

  event_packer #(.NCH(NCH), .EW(EW), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .done(done), .stall(stall), .start_time(start_time),
    .start_period(start_period), .energy(energy), .period_done(period_done), .period(period),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dropped(dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send_event(input logic [19:0] t, input logic [7:0] p8, input logic [NCH*EW-1:0] e);
    start_time   = t;
    start_period = {40'h0, p8};
    energy       = e;
    done         = 1'b1;
    tick();
    done         = 1'b0;
  endtask

  // Expected event words built from the documented frame format.
  task automatic fill_evt(input int base, input logic [19:0] t, input logic [7:0] p8,
                          input logic [NCH*EW-1:0] e);
    exp_w[base]     = {4'b1010, t[19:8]};
    exp_w[base + 1] = {t[7:0], p8};
    for (int c = 0; c < NCH; c++) exp_w[base + 2 + c] = e[c*EW +: EW];
  endtask

  // Collect nexp words; with bp set, ready follows a fixed irregular pattern and held words are checked.
  task automatic drain(input string tag, input int nexp, input int maxcyc, input bit bp);
    int k = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [15:0] held = '0;
    while (k < nexp && cyc < maxcyc) begin
      dout_ready = bp ? bp_pat[cyc % 16] : 1'b1;
      if (hold) begin
        check({tag, "_hold_valid"}, dout_valid, 1'b1);
        check({tag, "_hold_data"}, dout, held);
      end
      hold = 1'b0;
      if (dout_valid) begin
        if (dout_ready) begin
          check($sformatf("%s_w%0d", tag, k), dout, exp_w[k]);
          k++;
        end else begin
          hold = 1'b1;
          held = dout;
        end
      end
      tick();
      cyc++;
    end
    dout_ready = 1'b1;
    check({tag, "_word_count"}, k, nexp);
    if (k == nexp) check({tag, "_gap"}, dout_valid, 1'b0);
  endtask

  initial begin
    logic [NCH*EW-1:0] e;
    logic [19:0] t;
    logic [7:0] p8;

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_dout", dout, 16'h0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_dropped", dropped, 8'h0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: single event, exact latency
    dout_ready = 1'b1;
    exp_w[0] = 16'hAABC; exp_w[1] = 16'hDE5A; exp_w[2] = 16'h0001;
    exp_w[3] = 16'h0002; exp_w[4] = 16'h0003; exp_w[5] = 16'h0004;
    send_event(20'hABCDE, 8'h5A, {16'd4, 16'd3, 16'd2, 16'd1});
    check("t1_lat_n1_valid", dout_valid, 1'b0);
    check("t1_lat_n1_busy", busy, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_valid%0d", i), dout_valid, 1'b1);
      check($sformatf("t1_w%0d", i), dout, exp_w[i]);
      tick();
    end
    check("t1_end_valid", dout_valid, 1'b0);
    check("t1_dropped", dropped, 8'h0);
    check("t1_busy", busy, 1'b0);

    // 2: back-pressure on the same event
    dout_ready = 1'b0;
    send_event(20'hABCDE, 8'h5A, {16'd4, 16'd3, 16'd2, 16'd1});
    drain("t2", 6, 100, 1'b1);
    check("t2_dropped", dropped, 8'h0);

    // 3: overflow with ready low
    dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t  = 20'(32'h30000 + i * 32'h1111);
      p8 = 8'(8'h20 + i);
      for (int c = 0; c < NCH; c++) e[c*EW +: EW] = 16'(i * 16 + c + 1);
      if (i < 4) fill_evt(i * 6, t, p8, e);
      send_event(t, p8, e);
    end
    check("t3_dropped", dropped, 8'd2);
    check("t3_busy", busy, 1'b1);
    check("t3_valid_held", dout_valid, 1'b1);
    check("t3_first_word", dout, exp_w[0]);
    drain("t3", 24, 200, 1'b0);
    repeat (4) tick();
    check("t3_no_extra", dout_valid, 1'b0);
    check("t3_busy_end", busy, 1'b0);

    // 4: tag held off by stall, event goes first
    stall        = 1'b1;
    period       = 48'h0123_4567_89AB;
    period_done  = 1'b1;
    fill_evt(0, 20'h5_4321, 8'hC3, {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A});
    send_event(20'h5_4321, 8'hC3, {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A});
    period_done  = 1'b0;
    drain("t4_evt", 6, 50, 1'b0);
    repeat (3) tick();
    check("t4_stalled_valid", dout_valid, 1'b0);
    check("t4_stalled_busy", busy, 1'b1);
    stall = 1'b0;
    exp_w[0] = 16'hC012; exp_w[1] = 16'h3456; exp_w[2] = 16'h789A; exp_w[3] = 16'hB000;
    drain("t4_tag", 4, 50, 1'b0);
    check("t4_busy_end", busy, 1'b0);

    // 5: tag overwrite while stalled
    stall       = 1'b1;
    period      = 48'h1111_2222_3333;
    period_done = 1'b1;
    tick();
    period_done = 1'b0;
    tick();
    tick();
    period      = 48'hAAAA_BBBB_CCCD;
    period_done = 1'b1;
    tick();
    period_done = 1'b0;
    check("t5_stalled_valid", dout_valid, 1'b0);
    stall = 1'b0;
    exp_w[0] = 16'hCAAA; exp_w[1] = 16'hABBB; exp_w[2] = 16'hBCCC; exp_w[3] = 16'hD000;
    drain("t5", 4, 50, 1'b0);
    repeat (5) tick();
    check("t5_single_frame", dout_valid, 1'b0);
    check("t5_busy_end", busy, 1'b0);

    // 6: reset mid-frame
    check("t6_dropped_pre", dropped, 8'd2);
    dout_ready = 1'b1;
    send_event(20'h1_2345, 8'h77, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    tick();
    check("t6_w0", dout, 16'hA123);
    tick();
    check("t6_w1", dout, 16'h4577);
    tick();
    check("t6_w2", dout, 16'h1111);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_valid", dout_valid, 1'b0);
    check("t6_dout", dout, 16'h0);
    check("t6_dropped", dropped, 8'h0);
    check("t6_busy", busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t6_quiet%0d", i), dout_valid, 1'b0);
      tick();
    end
    fill_evt(0, 20'hF_0F0F, 8'h01, {16'h0008, 16'h0007, 16'h0006, 16'h0005});
    send_event(20'hF_0F0F, 8'h01, {16'h0008, 16'h0007, 16'h0006, 16'h0005});
    check("t6_new_lat", dout_valid, 1'b0);
    drain("t6_new", 6, 50, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
